// File: rtl/bbox_scan.sv
// Column-serial bounding-box scanner: accumulates a row mask and the first/last
// non-empty column, then resolves the four empty margins and the 2x-scale flags.
module bbox_scan #(
  parameter int ROWS      = 64,
  parameter int COLS      = 24,
  parameter int HSCALE_TH = 12,
  parameter int VSCALE_TH = 32,
  localparam int CW = $clog2(COLS + 1),
  localparam int RW = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ROWS-1:0] col_data,
  input  logic            col_valid,
  output logic            col_ready,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   lshift,
  output logic [CW-1:0]   rshift,
  output logic [RW-1:0]   tshift,
  output logic [RW-1:0]   bshift,
  output logic            hscale,
  output logic            vscale,
  output logic            blank
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   first_col;
  logic [CW-1:0]   last_col;
  logic            first_vld;
  logic [ROWS-1:0] mask;

  logic [CW-1:0]   l_nxt;
  logic [CW-1:0]   r_nxt;
  logic [RW-1:0]   t_nxt;
  logic [RW-1:0]   b_nxt;
  logic            hs_nxt;
  logic            vs_nxt;
  logic            blank_nxt;

  function automatic logic [RW-1:0] lowest_set(input logic [ROWS-1:0] m);
    logic [RW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (m[i]) r = RW'(i);
    return r;
  endfunction

  function automatic logic [RW-1:0] highest_set(input logic [ROWS-1:0] m);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < ROWS; i++)
      if (m[i]) r = RW'(i);
    return r;
  endfunction

  assign col_ready = (state == SCAN);
  assign busy      = (state == SCAN) || (state == RESOLVE);
  assign done      = (state == DONE);

  // Resolve values; an empty mask means no column ever carried a pixel.
  always_comb begin
    blank_nxt = (mask == '0);
    l_nxt     = CW'(COLS);
    r_nxt     = '0;
    t_nxt     = RW'(ROWS);
    b_nxt     = '0;
    hs_nxt    = 1'b0;
    vs_nxt    = 1'b0;
    if (!blank_nxt) begin
      l_nxt  = first_col;
      r_nxt  = CW'(COLS - 1) - last_col;
      t_nxt  = lowest_set(mask);
      b_nxt  = RW'(ROWS - 1) - highest_set(mask);
      hs_nxt = ({1'b0, l_nxt} + {1'b0, r_nxt}) >= (CW + 1)'(HSCALE_TH);
      vs_nxt = ({1'b0, t_nxt} + {1'b0, b_nxt}) >= (RW + 1)'(VSCALE_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state     <= rst ? IDLE : SCAN;
      idx       <= '0;
      mask      <= '0;
      first_col <= '0;
      first_vld <= 1'b0;
      last_col  <= '0;
      lshift    <= '0;
      rshift    <= '0;
      tshift    <= '0;
      bshift    <= '0;
      hscale    <= 1'b0;
      vscale    <= 1'b0;
      blank     <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (col_valid) begin
            mask <= mask | col_data;
            if (col_data != '0) begin
              if (!first_vld) begin
                first_col <= idx;
                first_vld <= 1'b1;
              end
              last_col <= idx;
            end
            // The index saturates at the last column instead of wrapping.
            if (idx == CW'(COLS - 1)) state <= RESOLVE;
            else                      idx   <= idx + CW'(1);
          end
        end
        RESOLVE: begin
          lshift <= l_nxt;
          rshift <= r_nxt;
          tshift <= t_nxt;
          bshift <= b_nxt;
          hscale <= hs_nxt;
          vscale <= vs_nxt;
          blank  <= blank_nxt;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bbox_scan.md
# bbox_scan

Parametrised bounding-box scanner for the compare accelerator. It accepts a glyph bitmap one column at a time and reports the empty margins on all four sides: left, right, top and bottom. It also reports the horizontal and vertical 2x-scale decisions with configurable thresholds. It sits between the column fetch stage and the compare ALU, and its outputs feed the shift and scale fields of the compare result.

## Interface
- ROWS, 64, bits per column (image height); bit 0 is the top row.
- COLS, 24, columns per image (image width); column 0 is the leftmost.
- HSCALE_TH, 12, horizontal scale threshold on lshift+rshift.
- VSCALE_TH, 32, vertical scale threshold on tshift+bshift.
- Derived widths: CW = $clog2(COLS+1), RW = $clog2(ROWS+1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins, or restarts, a scan.
- col_data  in  ROWS  current column bits.
- col_valid  in  1  col_data is valid.
- col_ready  out  1  block accepts a column this cycle.
- busy  out  1  high in SCAN and RESOLVE.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- lshift  out  CW  empty columns on the left.
- rshift  out  CW  empty columns on the right.
- tshift  out  RW  empty rows on top.
- bshift  out  RW  empty rows on the bottom.
- hscale  out  1  (lshift+rshift) >= HSCALE_TH.
- vscale  out  1  (tshift+bshift) >= VSCALE_TH.
- blank  out  1  every accepted column was all-zero.

## Operation
- States: IDLE, SCAN, RESOLVE, DONE.
- IDLE / DONE + start: clear the column counter, the row mask, the first/last column registers and all result outputs; go to SCAN.
- SCAN:
  - col_ready=1.
  - A column is accepted when col_valid & col_ready.
  - On accept: row mask |= col_data.
  - If col_data is nonzero: record first_col if none is recorded yet, and always set last_col = current index.
  - The column index increments by 1 per accept.
- Accepting column COLS-1 moves the block to RESOLVE. The index does not wrap, and no further columns are accepted.
- RESOLVE, one cycle, registers:
  - lshift = first_col.
  - rshift = COLS-1-last_col.
  - tshift = index of the lowest set mask bit.
  - bshift = ROWS-1 - index of the highest set mask bit.
  - hscale and vscale are computed with sums zero-extended by one bit (no overflow).
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs hold until the next start or rst.
- Blank image (no column nonzero):
  - blank=1, lshift=COLS, rshift=0, tshift=ROWS, bshift=0.
  - hscale=0 and vscale=0 (forced).
- start in SCAN or RESOLVE aborts the scan: clear as above and re-enter SCAN. start has priority over a same-cycle column; that column is discarded.
- col_valid outside SCAN is ignored. col_data is not sampled unless a column is accepted.
- Reset, including mid-scan:
  - State goes to IDLE.
  - Every output reads 0: col_ready, busy, done, all shifts, hscale, vscale, blank.
  - Internal mask and counters are cleared.

## Timing
- col_ready rises the cycle after start and is combinational from state only; it has no dependence on col_valid.
- Throughput is 1 column per cycle. Gaps in col_valid stall the scan without limit.
- Latency: the last column is accepted at edge N, RESOLVE runs in cycle N+1, and done is high in cycle N+2. With no gaps, done arrives COLS+2 cycles after the start cycle.
- busy is high from the cycle after start through RESOLVE, and low in DONE.
- start in the DONE cycle is legal: done still pulses that cycle, and SCAN begins on the next cycle.
- Result outputs change only in the RESOLVE→DONE edge, on start and on rst.

## Test plan
All scenarios use the defaults ROWS=64, COLS=24, HSCALE_TH=12, VSCALE_TH=32.
- **Normal glyph:** columns 0–4 zero; columns 5–19 = bits 10..40 set; columns 20–23 zero; no gaps → lshift=5, rshift=4, tshift=10, bshift=23, hscale=0, vscale=1, blank=0, done in cycle 26 after start.
- **Single pixel:** only column 23 bit 63 set → lshift=23, rshift=0, tshift=63, bshift=0, hscale=1, vscale=1.
- **Blank image:** all 24 columns zero → blank=1, lshift=24, rshift=0, tshift=64, bshift=0, hscale=0, vscale=0.
- **Backpressure:** repeat the normal glyph with col_valid toggling randomly → identical results, done exactly 2 cycles after the 24th accept, and col_ready=0 after that accept.
- **Abort:** start again after column 10 of an image where every column is all-ones, then feed the normal glyph → results match the normal glyph only, with exactly one done pulse.
- **Reset mid-scan:** assert rst at column 12 → all outputs 0, state IDLE; a following start plus the single-pixel image gives the single-pixel results.
